// File: rtl/seg_count_decoder_if.sv
// seg_count_decoder_if: valid/ready bus carrying one decoded vote-count transaction
interface seg_count_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_count;
  logic       out_err;
  modport master(output out_valid, out_count, out_err, input out_ready);
  modport slave(input out_valid, out_count, out_err, output out_ready);
endinterface

// File: rtl/seg_count_decoder.sv
// seg_count_decoder: debounce 7-line segment pattern, decode to count 0..5, deliver via valid/ready with skid.
// Optional SEG_ERR_COUNT_EN adds a saturating count of qualified out-of-table patterns.
module seg_count_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 seg_in,
  seg_count_decoder_if.master        out,
  output logic                       overrun
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]                 err_count
`endif
);
  typedef enum logic [1:0] {EMPTY, FULL, FULL_SKID} state_t;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
  state_t r_state, w_next;
  logic [6:0] r_samp, r_last;
  logic [CNT_W-1:0] r_stab;
  logic [2:0] r_cnt, r_skid_cnt, w_dec_cnt;
  logic r_err, r_skid_err, r_ovr, w_dec_err;
  logic w_qual, w_acc, w_load_out, w_load_skid, w_from_skid, w_ovr_set;
  always_comb begin
    w_dec_cnt = 3'd7;
    w_dec_err = 1'b0;
    case (r_samp)
      7'h6D: w_dec_cnt = 3'd0;
      7'h66: w_dec_cnt = 3'd1;
      7'h4F: w_dec_cnt = 3'd2;
      7'h5B: w_dec_cnt = 3'd3;
      7'h06: w_dec_cnt = 3'd4;
      7'h3D: w_dec_cnt = 3'd5;
      default: w_dec_err = 1'b1;
    endcase
  end
  // r_last starts at the 7'h7F sentinel so the first stable pattern after reset is always new
  assign w_qual = (r_stab == STAB_MAX) && (r_samp != r_last);
  assign w_acc = (r_state != EMPTY) && out.out_ready;
  always_comb begin
    w_next = r_state;
    w_load_out = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      EMPTY: begin
        w_load_out = w_qual;
        w_next = w_qual ? FULL : EMPTY;
      end
      FULL: begin
        w_load_out = w_acc && w_qual;
        w_load_skid = !w_acc && w_qual;
        w_next = w_qual ? (w_acc ? FULL : FULL_SKID) : (w_acc ? EMPTY : FULL);
      end
      FULL_SKID: begin
        w_from_skid = w_acc;
        w_load_skid = w_qual;
        w_ovr_set = !w_acc && w_qual;
        w_next = (w_acc && !w_qual) ? FULL : FULL_SKID;
      end
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_samp <= 7'h00;
      r_stab <= '0;
      r_last <= 7'h7F;
      r_cnt <= 3'd0;
      r_err <= 1'b0;
      r_skid_cnt <= 3'd0;
      r_skid_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_samp <= seg_in;
      r_stab <= (seg_in != r_samp) ? CNT_W'(1) : (r_stab == STAB_MAX ? r_stab : r_stab + 1'b1);
      if (w_qual) r_last <= r_samp;
      if (w_load_out) {r_cnt, r_err} <= {w_dec_cnt, w_dec_err};
      else if (w_from_skid) {r_cnt, r_err} <= {r_skid_cnt, r_skid_err};
      if (w_load_skid) {r_skid_cnt, r_skid_err} <= {w_dec_cnt, w_dec_err};
      if (w_ovr_set) r_ovr <= 1'b1;
    end
  end
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] r_err_count;
  always_ff @(posedge clk) begin
    if (rst) r_err_count <= 8'd0;
    else if (w_qual && w_dec_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end
  assign err_count = r_err_count;
`endif
  assign out.out_valid = (r_state != EMPTY);
  assign out.out_count = r_cnt;
  assign out.out_err = r_err;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_seg_count_decoder.sv
// tb_seg_count_decoder: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_seg_count_decoder;
  localparam int S = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic overrun;
  seg_count_decoder_if bus();
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  always #5 clk = ~clk;
  seg_count_decoder #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .out(bus),
    .overrun(overrun)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] codes[6] = '{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3D};
  logic [6:0] m_samp, m_last;
  int m_run, m_errs;
  logic m_ovr;
  logic [3:0] q[$];
  function automatic logic [3:0] decode(input logic [6:0] p);
    for (int i = 0; i < 6; i++) if (codes[i] == p) return {1'b0, 3'(i)};
    return 4'hF;
  endfunction
  function automatic logic [5:0] want();
    return {q.size() > 0, q.size() > 0 ? q[0] : 4'h0, m_ovr};
  endfunction
  function automatic logic [5:0] got();
    return {bus.out_valid, bus.out_valid ? {bus.out_err, bus.out_count} : 4'h0, overrun};
  endfunction
  // A pattern is a new transaction once it has been sampled S times in a row and differs from the last one taken
  task automatic cycle(input logic [6:0] s, input logic r, input logic rs);
    logic qual;
    logic [3:0] d;
    seg_in = s;
    bus.out_ready = r;
    rst = rs;
    if (rs) begin
      m_samp = 7'h00; m_run = 0; m_last = 7'h7F; m_ovr = 1'b0; m_errs = 0;
      q.delete();
    end else begin
      qual = (m_run >= S) && (m_samp != m_last);
      d = decode(m_samp);
      if (q.size() > 0 && r) void'(q.pop_front());
      if (qual) begin
        m_last = m_samp;
        if (d[3] && m_errs < 255) m_errs++;
        if (q.size() < 2) q.push_back(d);
        else begin q[1] = d; m_ovr = 1'b1; end
      end
      m_run = (s == m_samp) ? m_run + 1 : 1;
      m_samp = s;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) cycle(7'h5B, 1'b1, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_count, bus.out_err, overrun} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state got %b want 000000", {bus.out_valid, bus.out_count, bus.out_err, overrun});
    end
  endtask
  task automatic test_hold();
    for (int i = 1; i <= 12; i++) begin
      cycle(7'h5B, 1'b1, 1'b0);
      vectors++;
      if (bus.out_valid !== (i == 4) || (bus.out_valid && {bus.out_err, bus.out_count} !== 4'h3)) begin
        miscompares++;
        $display("FAIL hold_5B cyc %0d got v=%b e=%b c=%0d want v=%b c=3", i, bus.out_valid, bus.out_err, bus.out_count, i == 4);
      end
    end
  endtask
  task automatic test_all_codes();
    logic [2:0] obs[$];
    for (int k = 0; k < 6; k++)
      repeat (5) begin
        cycle(codes[k], 1'b1, 1'b0);
        if (bus.out_valid) obs.push_back(bus.out_count);
        vectors++;
        if (got() !== want()) begin
          miscompares++;
          $display("FAIL codes_model got %h want %h", got(), want());
        end
      end
    vectors++;
    if (obs.size() != 6) begin
      miscompares++;
      $display("FAIL codes_txn_count got %0d want 6", obs.size());
    end else
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (obs[k] !== 3'(k)) begin
          miscompares++;
          $display("FAIL codes_order idx %0d got %0d want %0d", k, obs[k], k);
        end
      end
  endtask
  task automatic test_err();
    int seen = 0;
    repeat (6) begin
      cycle(7'h7F, 1'b1, 1'b0);
      if (bus.out_valid) begin
        seen++;
        vectors++;
        if ({bus.out_err, bus.out_count} !== 4'hF) begin
          miscompares++;
          $display("FAIL err_decode got e=%b c=%0d want e=1 c=7", bus.out_err, bus.out_count);
        end
      end
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL err_txn_count got %0d want 1", seen);
    end
`ifdef SEG_ERR_COUNT_EN
    vectors++;
    if (err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL err_count got %0d want 1", err_count);
    end
`endif
  endtask
  task automatic test_glitch();
    int seen = 0;
    repeat (6) cycle(7'h66, 1'b1, 1'b0);
    repeat (2) begin
      cycle(7'h4F, 1'b1, 1'b0);
      if (bus.out_valid) seen++;
    end
    repeat (8) begin
      cycle(7'h66, 1'b1, 1'b0);
      if (bus.out_valid) seen++;
    end
    vectors++;
    if (seen != 0 || q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_txn got %0d want 0", seen);
    end
  endtask
  task automatic test_skid_overrun();
    logic [2:0] obs[$];
    logic [6:0] pats[3] = '{7'h6D, 7'h4F, 7'h06};
    for (int k = 0; k < 3; k++)
      repeat (5) begin
        cycle(pats[k], 1'b0, 1'b0);
        vectors++;
        if (got() !== want()) begin
          miscompares++;
          $display("FAIL skid_model got %h want %h", got(), want());
        end
      end
    vectors++;
    if ({bus.out_valid, bus.out_err, bus.out_count, overrun} !== 6'b100001) begin
      miscompares++;
      $display("FAIL skid_hold got %b want 100001", {bus.out_valid, bus.out_err, bus.out_count, overrun});
    end
    repeat (4) begin
      if (bus.out_valid) obs.push_back(bus.out_count);
      cycle(7'h06, 1'b1, 1'b0);
    end
    vectors++;
    if (obs.size() != 2 || obs[0] !== 3'd0 || obs[1] !== 3'd4) begin
      miscompares++;
      $display("FAIL skid_drain got n=%0d first=%0d second=%0d want n=2 0 4", obs.size(),
               obs.size() > 0 ? obs[0] : 3'd0, obs.size() > 1 ? obs[1] : 3'd0);
    end
  endtask
  task automatic test_reset_midflight();
    int seen = 0;
    repeat (5) cycle(7'h3D, 1'b0, 1'b0);
    repeat (5) cycle(7'h5B, 1'b0, 1'b0);
    vectors++;
    if (q.size() != 2 || got() !== want()) begin
      miscompares++;
      $display("FAIL midflight_setup got %h want %h", got(), want());
    end
    cycle(7'h5B, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL midflight_reset got v=%b ovr=%b want 0 0", bus.out_valid, overrun);
    end
    repeat (6) begin
      cycle(7'h5B, 1'b1, 1'b0);
      if (bus.out_valid) begin
        seen++;
        vectors++;
        if (bus.out_count !== 3'd3) begin
          miscompares++;
          $display("FAIL midflight_reemit got %0d want 3", bus.out_count);
        end
      end
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL midflight_txn_count got %0d want 1", seen);
    end
  endtask
  task automatic test_random();
    logic [6:0] p;
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 9) < 6) ? codes[$urandom_range(0, 5)] : 7'($urandom);
      repeat ($urandom_range(1, 6)) begin
        cycle(p, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        vectors++;
        if (got() !== want()) begin
          miscompares++;
          $display("FAIL random_model seg %h got %h want %h", p, got(), want());
        end
`ifdef SEG_ERR_COUNT_EN
        vectors++;
        if (err_count !== 8'(m_errs)) begin
          miscompares++;
          $display("FAIL random_err_count got %0d want %0d", err_count, m_errs);
        end
`endif
      end
    end
  endtask
  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_hold();
    test_all_codes();
    test_err();
    test_glitch();
    test_skid_overrun();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
